axi_rst_drain_seq: RTL
======================

Name: axi_rst_drain_seq

Overview:
- Consumer-side counterpart to the per-domain reset generators in the clock/reset map.
- On a soft reset request it gates new AXI address traffic and drains outstanding write and read transactions. It then asserts and releases interconnect and peripheral resets in order, and finally re-opens traffic.
- One instance sits in each AXI clock domain, between the interconnect reset outputs and the attached slave port.

Parameters:
- OUTST_W, 6, width of each outstanding-transaction counter; the counter saturates at 2^OUTST_W-1.
- HOLD_CYCLES, 16, minimum number of cycles both resets are held low in ASSERT (must be at least 1).
- PERIPH_DELAY, 4, cycles between interconnect release and peripheral release (must be at least 1).
- DRAIN_TIMEOUT, 1024, maximum number of DRAIN cycles before a forced reset; 0 disables the timeout.

Ports:
- aclk  in  1  domain clock; all logic is on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- rst_req  in  1  level soft-reset request; sampled only in RUN.
- s_awvalid, s_awready  in  1 each  AW handshake monitor.
- s_bvalid, s_bready  in  1 each  B handshake monitor.
- s_arvalid, s_arready  in  1 each  AR handshake monitor.
- s_rvalid, s_rready, s_rlast  in  1 each  R handshake monitor.
- traffic_en  out  1  1 = upstream may present AW/AR; the masking itself is external.
- interconnect_aresetn  out  1  active-low reset to interconnect logic.
- peripheral_aresetn  out  1  active-low reset to the attached slave.
- rst_busy  out  1  high in every state except RUN.
- drain_timeout  out  1  sticky; set when DRAIN exits by timeout, cleared only by aresetn.

Behaviour:
Asynchronous reset (aresetn=0):
- state=ASSERT, hold counter loaded with HOLD_CYCLES-1, wr_out=rd_out=0.
- interconnect_aresetn=0, peripheral_aresetn=0, traffic_en=0, rst_busy=1, drain_timeout=0.
- Reset assertion is asynchronous; deassertion is consumed synchronously on the next aclk edge.

General rules:
- All outputs are registered; there are no combinational paths from inputs to outputs.

Outstanding counters (active in RUN and DRAIN, cleared in ASSERT):
- wr_out increments on AW handshake (awvalid&awready) and decrements on B handshake.
- rd_out increments on AR handshake and decrements on R handshake with rlast=1.
- Increment and decrement in the same cycle leave the count unchanged.
- An increment at the maximum saturates; a decrement at 0 is ignored.

States:
- RUN: traffic_en=1, both resets high. If rst_req=1, the next state is DRAIN and traffic_en=0 from the next cycle. Handshakes in the transition cycle are still counted.
- DRAIN: traffic_en=0, both resets remain high.
  - The drain cycle counter starts at 0.
  - Exit to ASSERT when wr_out==0 and rd_out==0, evaluated on post-update counter values, so the final B/R can complete in the exit cycle.
  - If DRAIN_TIMEOUT!=0 and the cycle counter reaches DRAIN_TIMEOUT-1 without draining, go to ASSERT and set drain_timeout.
  - Deasserting rst_req in DRAIN does not abort; the sequence always completes.
- ASSERT: interconnect_aresetn=0, peripheral_aresetn=0, counters cleared.
  - Stay while the hold counter is non-zero or rst_req=1.
  - Then go to REL_IC, with the PERIPH_DELAY counter loaded to PERIPH_DELAY-1.
- REL_IC: interconnect_aresetn=1, peripheral_aresetn=0, traffic_en=0.
  - When the delay counter reaches 0, go to RUN.
  - peripheral_aresetn=1 and traffic_en=1 in the same first RUN cycle.
  - rst_req=1 in REL_IC is ignored; it is sampled again in RUN.

Latencies:
- rst_req rising in RUN with nothing outstanding: traffic_en falls after 1 cycle and interconnect_aresetn falls after 2 cycles.
- After aresetn release, with rst_req held low:
  - interconnect_aresetn rises HOLD_CYCLES cycles later.
  - peripheral_aresetn rises HOLD_CYCLES+PERIPH_DELAY cycles later.

Test Plan:
1. Power-up: aresetn low for 5 cycles, then high, rst_req=0, defaults -> both resets low; interconnect_aresetn rises 16 edges after release; peripheral_aresetn and traffic_en rise 4 edges after that; rst_busy falls with them.
2. Idle soft reset: in RUN with counters at 0, pulse rst_req for 1 cycle -> traffic_en=0 next cycle, resets low for exactly 16 cycles, then the release sequence as in test 1; drain_timeout stays 0.
3. Drain with outstanding traffic: 3 AW and 2 AR accepted, then rst_req=1 -> DRAIN holds until 3 B responses and 2 rlast beats complete; resets fall on the cycle after the last one; a same-cycle AW+B pair leaves wr_out unchanged.
4. Timeout: DRAIN_TIMEOUT=8, one AW accepted with no B ever returned -> ASSERT entered after 8 DRAIN cycles; drain_timeout=1 and stays 1 through RUN until aresetn is pulsed.
5. Extended hold: rst_req held high for 40 cycles -> resets stay low until rst_req falls, then release follows the normal delays; rst_req reasserted in REL_IC -> no effect until RUN, then a new DRAIN begins.
6. Reset mid-operation: aresetn pulsed low during DRAIN with wr_out=5 -> resets go low asynchronously, counters read 0, and the normal power-up release follows; counter saturation check: 70 AW with no B -> wr_out=63.

Source files
------------

// File: rtl/axi_rst_drain_seq.sv
// Soft-reset sequencer for one AXI clock domain: gates new address traffic, drains
// outstanding writes/reads, then asserts and releases interconnect and peripheral resets in order.
module axi_rst_drain_seq #(
  parameter int OUTST_W       = 6,
  parameter int HOLD_CYCLES   = 16,
  parameter int PERIPH_DELAY  = 4,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               rst_req,
  input  logic               s_awvalid,
  input  logic               s_awready,
  input  logic               s_bvalid,
  input  logic               s_bready,
  input  logic               s_arvalid,
  input  logic               s_arready,
  input  logic               s_rvalid,
  input  logic               s_rready,
  input  logic               s_rlast,
  output logic               traffic_en,
  output logic               interconnect_aresetn,
  output logic               peripheral_aresetn,
  output logic               rst_busy,
  output logic               drain_timeout,
  output logic [1:0]         dbg_state,
  output logic [OUTST_W-1:0] dbg_wr_out,
  output logic [OUTST_W-1:0] dbg_rd_out
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_ASSERT = 2'd2,
    ST_REL_IC = 2'd3
  } state_t;

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int PW = (PERIPH_DELAY > 1) ? $clog2(PERIPH_DELAY) : 1;
  localparam int DW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

  localparam logic [OUTST_W-1:0] OUT_MAX    = '1;
  localparam logic [HW-1:0]      HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0]      DLY_LOAD   = PW'(PERIPH_DELAY - 1);
  localparam logic [DW-1:0]      DRAIN_LAST = DW'((DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0);

  state_t               state, state_next;
  logic [OUTST_W-1:0]   wr_out, wr_next, rd_out, rd_next;
  logic [HW-1:0]        hold_cnt, hold_next;
  logic [PW-1:0]        dly_cnt, dly_next;
  logic [DW-1:0]        drain_cnt, drain_next;
  logic                 to_next;

  // Handshake monitors: a transfer is counted in any cycle where valid and ready are both high.
  logic aw_hs, b_hs, ar_hs, rl_hs;
  assign aw_hs = s_awvalid & s_awready;
  assign b_hs  = s_bvalid & s_bready;
  assign ar_hs = s_arvalid & s_arready;
  assign rl_hs = s_rvalid & s_rready & s_rlast;

  function automatic logic [OUTST_W-1:0] count_upd(input logic [OUTST_W-1:0] cnt,
                                                   input logic inc, input logic dec);
    logic [OUTST_W-1:0] res;
    res = cnt;
    if (inc && !dec && cnt != OUT_MAX) res = cnt + 1'b1;
    if (dec && !inc && cnt != '0)      res = cnt - 1'b1;
    return res;
  endfunction

  always_comb begin
    state_next = state;
    wr_next    = wr_out;
    rd_next    = rd_out;
    hold_next  = hold_cnt;
    dly_next   = dly_cnt;
    drain_next = drain_cnt;
    to_next    = drain_timeout;
    case (state)
      ST_RUN: begin
        wr_next = count_upd(wr_out, aw_hs, b_hs);
        rd_next = count_upd(rd_out, ar_hs, rl_hs);
        if (rst_req) begin
          state_next = ST_DRAIN;
          drain_next = '0;
        end
      end
      ST_DRAIN: begin
        wr_next = count_upd(wr_out, aw_hs, b_hs);
        rd_next = count_upd(rd_out, ar_hs, rl_hs);
        // Exit test uses the post-update counts so the last response can finish this cycle.
        if (wr_next == '0 && rd_next == '0) begin
          state_next = ST_ASSERT;
          hold_next  = HOLD_LOAD;
        end else if (DRAIN_TIMEOUT != 0 && drain_cnt == DRAIN_LAST) begin
          state_next = ST_ASSERT;
          hold_next  = HOLD_LOAD;
          to_next    = 1'b1;
          wr_next    = '0;
          rd_next    = '0;
        end else begin
          drain_next = drain_cnt + 1'b1;
        end
      end
      ST_ASSERT: begin
        wr_next = '0;
        rd_next = '0;
        if (hold_cnt != '0) begin
          hold_next = hold_cnt - 1'b1;
        end else if (!rst_req) begin
          state_next = ST_REL_IC;
          dly_next   = DLY_LOAD;
        end
      end
      ST_REL_IC: begin
        wr_next = '0;
        rd_next = '0;
        if (dly_cnt == '0) state_next = ST_RUN;
        else               dly_next   = dly_cnt - 1'b1;
      end
      default: state_next = ST_ASSERT;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state                <= ST_ASSERT;
      wr_out               <= '0;
      rd_out               <= '0;
      hold_cnt             <= HOLD_LOAD;
      dly_cnt              <= '0;
      drain_cnt            <= '0;
      drain_timeout        <= 1'b0;
      traffic_en           <= 1'b0;
      interconnect_aresetn <= 1'b0;
      peripheral_aresetn   <= 1'b0;
      rst_busy             <= 1'b1;
    end else begin
      state                <= state_next;
      wr_out               <= wr_next;
      rd_out               <= rd_next;
      hold_cnt             <= hold_next;
      dly_cnt              <= dly_next;
      drain_cnt            <= drain_next;
      drain_timeout        <= to_next;
      traffic_en           <= (state_next == ST_RUN);
      interconnect_aresetn <= (state_next != ST_ASSERT);
      peripheral_aresetn   <= (state_next == ST_RUN) || (state_next == ST_DRAIN);
      rst_busy             <= (state_next != ST_RUN);
    end
  end

  assign dbg_state  = state;
  assign dbg_wr_out = wr_out;
  assign dbg_rd_out = rd_out;

endmodule
